// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: frame FSM states, byte0 flag positions and
// the sign/magnitude helper used when a packet is published.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int unsigned PS2_SYNC_BIT = 3;

    localparam int unsigned B0_L  = 0;
    localparam int unsigned B0_R  = 1;
    localparam int unsigned B0_M  = 2;
    localparam int unsigned B0_XS = 4;
    localparam int unsigned B0_YS = 5;
    localparam int unsigned B0_XO = 6;
    localparam int unsigned B0_YO = 7;

    localparam logic [7:0] MAG_SAT = 8'd255;

    // |{sign,value}| as 9 bits; 256 (value 0, sign 1) and overflow both saturate
    function automatic logic [7:0] ps2_magnitude(input logic       sign,
                                                 input logic [7:0] value,
                                                 input logic       ovf);
        logic [8:0] mag;
        mag = sign ? (9'd256 - {1'b0, value}) : {1'b0, value};
        return (ovf || mag[8]) ? MAG_SAT : mag[7:0];
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device->host byte receiver: pin synchronisers, ps2_clk glitch filter,
// start/data/parity/stop frame FSM and inactivity timeout.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          clk_filt;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] to_cnt;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic          flip, fall, to_hit;

    // flip: filtered clock changes this cycle after FILTER_LEN differing samples
    assign flip    = (clk_sync != clk_filt) && (flt_cnt == FW'(FILTER_LEN - 1));
    assign fall    = flip && clk_filt;
    assign to_hit  = !flip && (to_cnt == TW'(TIMEOUT - 1));
    assign busy    = (state != IDLE);
    assign rx_byte = shreg;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            to_cnt   <= '0;
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            byte_ok  <= 1'b0;
            byte_err <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
            byte_ok  <= 1'b0;
            byte_err <= 1'b0;
            timeout  <= to_hit;

            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flip) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end

            if (flip) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (to_hit) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, dat_sync};
                        state  <= STOP;
                    end
                    default: begin
                        if (dat_sync && par_ok) byte_ok  <= 1'b1;
                        else                    byte_err <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse front end: assembles 3-byte stream packets into sign/magnitude
// movement, button levels and a stretched mouse_valid strobe.
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned TIMEOUT      = 50000,
    parameter int unsigned VALID_CYCLES = 2
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic       mouse_x_sign,
    output logic       mouse_y_sign,
    output logic       mouse_l_click,
    output logic       mouse_r_click,
    output logic       mouse_valid,
    output logic       frame_err
);

    localparam int unsigned VW = $clog2(VALID_CYCLES + 1);

    logic [7:0]    rx_byte;
    logic          byte_ok, byte_err, timeout, busy;
    logic [1:0]    pkt_idx;
    logic          hdr_l, hdr_r, hdr_xs, hdr_ys, hdr_xo, hdr_yo;
    logic [7:0]    x_byte;
    logic [VW-1:0] vcnt;

    ps2_rx_byte #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_ok   (byte_ok),
        .byte_err  (byte_err),
        .timeout   (timeout),
        .busy      (busy)
    );

    assign mouse_valid = (vcnt != '0);

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            pkt_idx       <= '0;
            hdr_l         <= 1'b0;
            hdr_r         <= 1'b0;
            hdr_xs        <= 1'b0;
            hdr_ys        <= 1'b0;
            hdr_xo        <= 1'b0;
            hdr_yo        <= 1'b0;
            x_byte        <= '0;
            vcnt          <= '0;
            mouse_x       <= '0;
            mouse_y       <= '0;
            mouse_x_sign  <= 1'b0;
            mouse_y_sign  <= 1'b0;
            mouse_l_click <= 1'b0;
            mouse_r_click <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (vcnt != '0) vcnt <= vcnt - VW'(1);

            if (byte_err) begin
                pkt_idx   <= '0;
                frame_err <= 1'b1;
            end else if (timeout) begin
                // only an abandoned partial frame or packet is an error
                frame_err <= busy || (pkt_idx != '0);
                pkt_idx   <= '0;
            end else if (byte_ok) begin
                case (pkt_idx)
                    2'd0: begin
                        if (rx_byte[PS2_SYNC_BIT]) begin
                            hdr_l   <= rx_byte[B0_L];
                            hdr_r   <= rx_byte[B0_R];
                            hdr_xs  <= rx_byte[B0_XS];
                            hdr_ys  <= rx_byte[B0_YS];
                            hdr_xo  <= rx_byte[B0_XO];
                            hdr_yo  <= rx_byte[B0_YO];
                            pkt_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        x_byte  <= rx_byte;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        mouse_x       <= ps2_magnitude(hdr_xs, x_byte, hdr_xo);
                        mouse_y       <= ps2_magnitude(hdr_ys, rx_byte, hdr_yo);
                        mouse_x_sign  <= hdr_xs;
                        mouse_y_sign  <= hdr_ys;
                        mouse_l_click <= hdr_l;
                        mouse_r_click <= hdr_r;
                        vcnt          <= VW'(VALID_CYCLES);
                        pkt_idx       <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: bit-banged PS/2 frames, directed and random
// packets checked against a sign/magnitude reference model.
module tb_ps2_mouse_packet_rx;

    localparam int unsigned TO   = 2000;
    localparam int unsigned HALF = 40;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic [7:0] mouse_x, mouse_y;
    logic       mouse_x_sign, mouse_y_sign, mouse_l_click, mouse_r_click;
    logic       mouse_valid, frame_err;

    int checks = 0;
    int errors = 0;

    int          valid_pulses = 0;
    int          err_cycles   = 0;
    int          run          = 0;
    int          last_width   = 0;
    logic        prev_valid   = 1'b0;
    logic [19:0] cap          = '0;

    ps2_mouse_packet_rx #(
        .FILTER_LEN   (8),
        .TIMEOUT      (TO),
        .VALID_CYCLES (2)
    ) dut (
        .clk_50MHz     (clk_50MHz),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .mouse_x       (mouse_x),
        .mouse_y       (mouse_y),
        .mouse_x_sign  (mouse_x_sign),
        .mouse_y_sign  (mouse_y_sign),
        .mouse_l_click (mouse_l_click),
        .mouse_r_click (mouse_r_click),
        .mouse_valid   (mouse_valid),
        .frame_err     (frame_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) begin
        if (mouse_valid) begin
            run = run + 1;
            if (!prev_valid) begin
                valid_pulses = valid_pulses + 1;
                cap = {mouse_x, mouse_x_sign, mouse_y, mouse_y_sign, mouse_l_click, mouse_r_click};
            end
        end else if (run != 0) begin
            last_width = run;
            run = 0;
        end
        if (frame_err) err_cycles = err_cycles + 1;
        prev_valid = mouse_valid;
    end

    function automatic logic [19:0] model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy, mx, my;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        mx = (dx < 0) ? -dx : dx;
        my = (dy < 0) ? -dy : dy;
        if (b0[6] || mx > 255) mx = 255;
        if (b0[7] || my > 255) my = 255;
        return {mx[7:0], b0[4], my[7:0], b0[5], b0[0], b0[1]};
    endfunction

    function automatic logic [19:0] pkt(input int x, input bit xs, input int y, input bit ys,
                                        input bit l, input bit r);
        return {x[7:0], xs, y[7:0], ys, l, r};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_50MHz);
            ps2_data = fr[i];
            idle(HALF / 2 - 4);
            if (glitch) begin
                ps2_clk = 1'b0;
                idle(1);
                ps2_clk = 1'b1;
            end
            idle(3);
            ps2_clk = 1'b0;
            idle(HALF / 2);
            if (glitch) begin
                ps2_clk = 1'b1;
                idle(1);
                ps2_clk = 1'b0;
            end
            idle(HALF / 2);
            ps2_clk = 1'b1;
            idle(HALF / 2);
        end
        ps2_data = 1'b1;
        idle(10);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input bit glitch);
        send_byte(b0, 1'b0, glitch, 11);
        send_byte(b1, 1'b0, glitch, 11);
        send_byte(b2, 1'b0, glitch, 11);
        idle(20);
    endtask

    task automatic test_reset();
        logic [20:0] outs;
        reset = 1'b1;
        idle(5);
        outs = {mouse_x, mouse_y, mouse_x_sign, mouse_y_sign, mouse_l_click, mouse_r_click, mouse_valid, frame_err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_basic();
        int p0;
        p0 = valid_pulses;
        send_packet(8'h08, 8'h05, 8'h03, 1'b0);
        checks++;
        if (valid_pulses - p0 != 1) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 1", valid_pulses - p0);
        end
        checks++;
        if (cap !== pkt(5, 0, 3, 0, 0, 0)) begin
            errors++;
            $display("FAIL basic_data: got %h want %h", cap, pkt(5, 0, 3, 0, 0, 0));
        end
        checks++;
        if (last_width != 2) begin
            errors++;
            $display("FAIL valid_width: got %0d want 2", last_width);
        end
    endtask

    task automatic test_signs();
        send_packet(8'h39, 8'hFB, 8'hFE, 1'b0);
        checks++;
        if (cap !== pkt(5, 1, 2, 1, 1, 0)) begin
            errors++;
            $display("FAIL signs_data: got %h want %h", cap, pkt(5, 1, 2, 1, 1, 0));
        end
        send_packet(8'h18, 8'h00, 8'h00, 1'b0);
        checks++;
        if (cap !== pkt(255, 1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL sat_256: got %h want %h", cap, pkt(255, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_overflow();
        int e0;
        e0 = err_cycles;
        send_packet(8'h4A, 8'h10, 8'h10, 1'b0);
        checks++;
        if (cap !== pkt(255, 0, 16, 0, 0, 1)) begin
            errors++;
            $display("FAIL overflow_data: got %h want %h", cap, pkt(255, 0, 16, 0, 0, 1));
        end
        checks++;
        if (err_cycles != e0) begin
            errors++;
            $display("FAIL overflow_err: got %0d want 0", err_cycles - e0);
        end
    endtask

    task automatic test_sync_parity();
        int p0, e0;
        p0 = valid_pulses;
        e0 = err_cycles;
        send_byte(8'h05, 1'b0, 1'b0, 11);
        send_packet(8'h08, 8'h01, 8'h01, 1'b0);
        checks++;
        if (valid_pulses - p0 != 1 || err_cycles != e0) begin
            errors++;
            $display("FAIL sync_skip: got pulses %0d errs %0d want 1 0", valid_pulses - p0, err_cycles - e0);
        end
        checks++;
        if (cap !== pkt(1, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL sync_data: got %h want %h", cap, pkt(1, 0, 1, 0, 0, 0));
        end
        p0 = valid_pulses;
        send_byte(8'h08, 1'b0, 1'b0, 11);
        send_byte(8'h20, 1'b1, 1'b0, 11);
        idle(20);
        checks++;
        if (err_cycles - e0 != 1 || valid_pulses != p0) begin
            errors++;
            $display("FAIL parity_err: got errs %0d pulses %0d want 1 0", err_cycles - e0, valid_pulses - p0);
        end
        send_packet(8'h08, 8'h06, 8'h07, 1'b0);
        checks++;
        if (cap !== pkt(6, 0, 7, 0, 0, 0) || valid_pulses - p0 != 1) begin
            errors++;
            $display("FAIL parity_recover: got %h want %h", cap, pkt(6, 0, 7, 0, 0, 0));
        end
    endtask

    task automatic test_timeout();
        int p0, e0;
        p0 = valid_pulses;
        e0 = err_cycles;
        send_byte(8'h08, 1'b0, 1'b0, 11);
        send_byte(8'h05, 1'b0, 1'b0, 11);
        idle(2 * TO);
        checks++;
        if (err_cycles - e0 != 1 || valid_pulses != p0) begin
            errors++;
            $display("FAIL timeout_err: got errs %0d pulses %0d want 1 0", err_cycles - e0, valid_pulses - p0);
        end
        send_packet(8'h28, 8'h0A, 8'h0B, 1'b0);
        checks++;
        if (cap !== pkt(10, 0, 245, 1, 0, 0) || valid_pulses - p0 != 1) begin
            errors++;
            $display("FAIL timeout_recover: got %h want %h", cap, pkt(10, 0, 245, 1, 0, 0));
        end
    endtask

    task automatic test_glitch_reset();
        int p0, e0;
        logic [20:0] outs;
        p0 = valid_pulses;
        e0 = err_cycles;
        send_packet(8'h09, 8'h7F, 8'h81, 1'b1);
        checks++;
        if (cap !== pkt(127, 0, 129, 0, 1, 0) || valid_pulses - p0 != 1 || err_cycles != e0) begin
            errors++;
            $display("FAIL glitch_data: got %h want %h", cap, pkt(127, 0, 129, 0, 1, 0));
        end
        p0 = valid_pulses;
        send_byte(8'h08, 1'b0, 1'b0, 11);
        send_byte(8'hA5, 1'b0, 1'b0, 5);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(30);
        outs = {mouse_x, mouse_y, mouse_x_sign, mouse_y_sign, mouse_l_click, mouse_r_click, mouse_valid, frame_err};
        checks++;
        if (outs !== '0 || valid_pulses != p0 || err_cycles != e0) begin
            errors++;
            $display("FAIL midframe_reset: got %h pulses %0d errs %0d want 0 0 0",
                     outs, valid_pulses - p0, err_cycles - e0);
        end
        send_packet(8'h1B, 8'hF0, 8'h22, 1'b0);
        checks++;
        if (cap !== model(8'h1B, 8'hF0, 8'h22) || valid_pulses - p0 != 1) begin
            errors++;
            $display("FAIL reset_recover: got %h want %h", cap, model(8'h1B, 8'hF0, 8'h22));
        end
    endtask

    task automatic test_random();
        logic [7:0] b0, b1, b2;
        int p0;
        for (int n = 0; n < 8; n++) begin
            b0 = 8'($urandom);
            b0[3] = 1'b1;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            p0 = valid_pulses;
            send_packet(b0, b1, b2, n[0]);
            checks++;
            if (cap !== model(b0, b1, b2) || valid_pulses - p0 != 1) begin
                errors++;
                $display("FAIL random_pkt %02h %02h %02h: got %h want %h", b0, b1, b2, cap, model(b0, b1, b2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_sync_parity();
        test_timeout();
        test_glitch_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
